// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - 640x480@60 timing, sync and frame-aligned pattern-select sequencer
// Optional macro VGA_AUTO_CYCLE_EN: advance the pattern every FRAMES_PER_PATTERN frames as well.
module vga_pattern_sequencer #(
  parameter int HVID               = 640,
  parameter int HFP                = 16,
  parameter int HSW                = 96,
  parameter int HBP                = 48,
  parameter int VVID               = 480,
  parameter int VFP                = 10,
  parameter int VSW                = 2,
  parameter int VBP                = 33,
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       next_req,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       load_enable,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [1:0] pattern_sel,
  output logic       next_ack
);
  localparam int HTOT = HVID + HFP + HSW + HBP;
  localparam int VTOT = VVID + VFP + VSW + VBP;
  localparam logic [9:0] H_LAST = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST = 10'(VTOT - 1);
  localparam logic [9:0] H_VID  = 10'(HVID);
  localparam logic [9:0] V_VID  = 10'(VVID);
  localparam logic [9:0] HS_BEG = 10'(HVID + HFP);
  localparam logic [9:0] HS_END = 10'(HVID + HFP + HSW - 1);
  localparam logic [9:0] VS_BEG = 10'(VVID + VFP);
  localparam logic [9:0] VS_END = 10'(VVID + VFP + VSW - 1);
  localparam logic [1:0] P_LAST = 2'(NUM_PATTERNS - 1);
  localparam logic [6:0] F_LAST = 7'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [1:0] {RUN, PEND, ACKW} state_e;

  state_e     state_q;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [1:0] pat_q, pat_d;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic       hsync_q, vsync_q;
  logic       h_end, frame_end, manual_adv, auto_adv, advance;

  always_comb begin
    h_end     = (h_cnt_q == H_LAST);
    frame_end = h_end && (v_cnt_q == V_LAST);
    h_cnt_d   = h_end ? '0 : h_cnt_q + 10'd1;
    v_cnt_d   = v_cnt_q;
    if (h_end) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;

    manual_adv = (state_q == PEND) && frame_end;
`ifdef VGA_AUTO_CYCLE_EN
    auto_adv   = frame_end && (frame_cnt_q == F_LAST);
`else
    auto_adv   = 1'b0;
`endif
    // A manual and an auto advance landing on the same frame_end merge into one step.
    advance = manual_adv || auto_adv;

    pat_d = pat_q;
    if (advance) pat_d = (pat_q == P_LAST) ? '0 : pat_q + 2'd1;

    frame_cnt_d = frame_cnt_q;
    if (advance)        frame_cnt_d = '0;
    else if (frame_end) frame_cnt_d = frame_cnt_q + 7'd1;
  end

`ifndef VGA_AUTO_CYCLE_EN
  logic unused_flast;
  assign unused_flast = ^F_LAST;
`endif

  always_ff @(posedge clk_25) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      pat_q       <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      state_q     <= RUN;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
      // Syncs lag the counters by one cycle to line up with the registered colour path.
      hsync_q     <= !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      vsync_q     <= !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      case (state_q)
        RUN:     if (next_req)  state_q <= PEND;
        PEND:    if (frame_end) state_q <= ACKW;
        ACKW:    if (!next_req) state_q <= RUN;
        default:                state_q <= RUN;
      endcase
    end
  end

  assign horizontal_num = h_cnt_q;
  assign vertical_num   = v_cnt_q;
  assign load_enable    = reset || (h_cnt_q >= H_VID) || (v_cnt_q >= V_VID);
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign frame_start    = !reset && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign pattern_sel    = pat_q;
  assign next_ack       = !reset && manual_adv;
endmodule
